// File: rtl/q1_fetch_ctrl_pkg.sv
// Shared types for the Q1 fetch stage: the Q1/Q2 pipeline bundle, the fetch FSM
// states and the NOP used for bubbles.
package q1_fetch_ctrl_pkg;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] pc_incr;
    } q1q2_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // A real instruction always carries its sequential successor address.
    function automatic q1q2_t make_bundle(input logic [31:0] insn, input logic [31:0] pc);
        q1q2_t b;
        b.insn    = insn;
        b.pc      = pc;
        b.pc_incr = pc + 32'd4;
        return b;
    endfunction

endpackage

// File: rtl/q1_fetch_ctrl_skid.sv
// One-entry skid buffer {insn, pc} that catches an instruction-memory response
// arriving while Q2 holds the presented bundle.
module q1_fetch_ctrl_skid (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_insn,
    input  logic [31:0] in_pc,
    input  logic        out_ready,
    output logic        full,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || flush) begin
            full <= 1'b0;
        end else if (in_valid) begin
            full <= 1'b1;
        end else if (out_ready) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload is deliberately not reset; it is only ever read while full=1.
    always_ff @(posedge i_clk) begin
        if (in_valid) begin
            out_insn <= in_insn;
            out_pc   <= in_pc;
        end
    end

endmodule

// File: rtl/q1_fetch_ctrl.sv
// Q1 fetch sequencer: owns the PC, keeps one instruction-memory request in flight,
// and presents a registered {insn, pc, pc_incr} bundle to the Q1/Q2 register.
module q1_fetch_ctrl
    import q1_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output q1q2_t       o_q1q2,
    output logic        o_q1q2_valid
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  fetch_pc;
    logic         kill;

    logic         skid_full;
    logic [31:0]  skid_insn;
    logic [31:0]  skid_pc;

    logic         accept;
    logic         cur_load;
    logic         skid_push;
    logic         redirect_kill;
    q1q2_t        cur_next;
    logic         valid_next;

    // A response is consumed only when it belongs to the current path.
    assign accept        = (state == WAIT) && i_imem_rvalid && !kill && !i_redirect;
    assign cur_load      = !i_stall || !o_q1q2_valid;
    assign skid_push     = accept && !cur_load;
    assign redirect_kill = ((state == WAIT) && !i_imem_rvalid) ||
                           ((state == REQ)  && i_imem_gnt);

    assign o_imem_req  = (state == REQ);
    assign o_imem_addr = pc;

    q1_fetch_ctrl_skid u_skid (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .flush     (i_redirect),
        .in_valid  (skid_push),
        .in_insn   (i_imem_rdata),
        .in_pc     (fetch_pc),
        .out_ready (cur_load),
        .full      (skid_full),
        .out_insn  (skid_insn),
        .out_pc    (skid_pc)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cur_next   = o_q1q2;
        valid_next = o_q1q2_valid;
        if (i_redirect) begin
            cur_next.insn = NOP_INSN;
            valid_next    = 1'b0;
        end else if (cur_load) begin
            if (skid_full) begin
                cur_next   = make_bundle(skid_insn, skid_pc);
                valid_next = 1'b1;
            end else if (accept) begin
                cur_next   = make_bundle(i_imem_rdata, fetch_pc);
                valid_next = 1'b1;
            end else begin
                cur_next.insn = NOP_INSN;
                valid_next    = 1'b0;
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            fetch_pc     <= 32'h0;
            kill         <= 1'b0;
            o_q1q2       <= '{insn: NOP_INSN, pc: 32'h0, pc_incr: 32'h0};
            o_q1q2_valid <= 1'b0;
        end else begin
            o_q1q2       <= cur_next;
            o_q1q2_valid <= valid_next;
            if (i_redirect) begin
                // With a response still owed, wait it out in WAIT before refetching.
                pc    <= {i_redirect_pc[31:2], 2'b00};
                kill  <= redirect_kill;
                state <= redirect_kill ? WAIT : REQ;
            end else begin
                case (state)
                    IDLE: begin
                        if (!skid_full) state <= REQ;
                    end
                    REQ: begin
                        if (i_imem_gnt) begin
                            fetch_pc <= pc;
                            pc       <= pc + 32'd4;
                            state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (i_imem_rvalid) begin
                            kill  <= 1'b0;
                            state <= skid_push ? IDLE : REQ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
